// File: rtl/ahb_master_arbiter.sv
// AHB multi-master arbiter: one-hot grant, address/data-phase owner indices, lock and burst aware handover.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module ahb_master_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    localparam int MIDX_W        = $clog2(NUM_MASTERS)
) (
    input  logic                   Hclk,
    input  logic                   Hresetn,
    input  logic [NUM_MASTERS-1:0] Hbusreq_M,
    input  logic [NUM_MASTERS-1:0] Hlock_M,
    input  logic [1:0]             Htrans,
    input  logic [2:0]             Hburst,
    input  logic                   Hready,
    output logic [NUM_MASTERS-1:0] Hgrant_M,
    output logic [MIDX_W-1:0]      Hmaster,
    output logic [MIDX_W-1:0]      Hmaster_d,
    output logic                   Hmastlock
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [MIDX_W-1:0]      DEFAULT_IDX = MIDX_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEFAULT_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MIDX_W-1:0]      aowner_q;
    logic [MIDX_W-1:0]      downer_q;
    logic                   lock_q, lock_d;
    logic [3:0]             rem_q, rem_d;
    logic [MIDX_W-1:0]      grant_idx;
    logic [MIDX_W-1:0]      win_idx;
    logic                   any_req;
    logic                   arb_point;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) grant_idx = MIDX_W'(i);
        end
    end

    // Remaining beats of the current fixed-length burst after this edge.
    always_comb begin
        rem_d = rem_q;
        unique case (Htrans)
            TR_NONSEQ: begin
                unique case (Hburst)
                    3'b000, 3'b001: rem_d = 4'd0;
                    3'b010, 3'b011: rem_d = 4'd3;
                    3'b100, 3'b101: rem_d = 4'd7;
                    default:        rem_d = 4'd15;
                endcase
            end
            TR_SEQ:  rem_d = (rem_q != 4'd0) ? rem_q - 4'd1 : 4'd0;
            TR_IDLE: rem_d = 4'd0;
            TR_BUSY: rem_d = rem_q;
            default: rem_d = rem_q;
        endcase
    end

    // Frozen while the owner still asks for lock or the current address phase is locked,
    // so one unlocked transfer always separates a locked sequence from the next owner.
    assign lock_d    = Hlock_M[grant_idx];
    assign arb_point = (rem_d == 4'd0) && !lock_d && !lock_q;
    assign any_req   = |Hbusreq_M;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        win_idx = DEFAULT_IDX;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (Hbusreq_M[i]) win_idx = MIDX_W'(i);
        end
    end

    always_comb begin
        grant_d = grant_q;
        if (arb_point) begin
            grant_d = any_req ? (NUM_MASTERS'(1) << win_idx) : DEFAULT_OH;
        end
    end
`else
    logic [MIDX_W-1:0] last_q, last_d;

    always_comb begin
        logic found;
        int   cand;
        found   = 1'b0;
        cand    = 0;
        win_idx = DEFAULT_IDX;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = (int'(last_q) + k) % NUM_MASTERS;
            if (!found && Hbusreq_M[cand]) begin
                found   = 1'b1;
                win_idx = MIDX_W'(cand);
            end
        end
    end

    always_comb begin
        grant_d = grant_q;
        last_d  = last_q;
        if (arb_point) begin
            if (any_req) begin
                grant_d = NUM_MASTERS'(1) << win_idx;
                last_d  = win_idx;
            end else begin
                grant_d = DEFAULT_OH;
            end
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            last_q <= DEFAULT_IDX;
        end else if (Hready) begin
            last_q <= last_d;
        end
    end
`endif

    // Every register holds through slave wait states.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            grant_q  <= DEFAULT_OH;
            aowner_q <= DEFAULT_IDX;
            downer_q <= DEFAULT_IDX;
            lock_q   <= 1'b0;
            rem_q    <= 4'd0;
        end else if (Hready) begin
            grant_q  <= grant_d;
            aowner_q <= grant_idx;
            downer_q <= aowner_q;
            lock_q   <= lock_d;
            rem_q    <= rem_d;
        end
    end

    assign Hgrant_M  = grant_q;
    assign Hmaster   = aowner_q;
    assign Hmaster_d = downer_q;
    assign Hmastlock = lock_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: parking, round-robin/fixed priority, burst, wait-state, lock and reset.
module tb_ahb_master_arbiter;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       Hclk;
    logic       Hresetn;
    logic [3:0] Hbusreq_M;
    logic [3:0] Hlock_M;
    logic [1:0] Htrans;
    logic [2:0] Hburst;
    logic       Hready;
    logic [3:0] Hgrant_M;
    logic [1:0] Hmaster;
    logic [1:0] Hmaster_d;
    logic       Hmastlock;

    int n_checks = 0;
    int n_errors = 0;

    ahb_master_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hbusreq_M (Hbusreq_M),
        .Hlock_M   (Hlock_M),
        .Htrans    (Htrans),
        .Hburst    (Hburst),
        .Hready    (Hready),
        .Hgrant_M  (Hgrant_M),
        .Hmaster   (Hmaster),
        .Hmaster_d (Hmaster_d),
        .Hmastlock (Hmastlock)
    );

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        end else begin
            $display("check %s: %0h ok", tag, obs);
        end
    endtask

    task automatic check_bus(input string tag, input logic [3:0] g, input int m, input int md, input logic l);
        check({tag, ".grant"}, 32'(Hgrant_M), 32'(g));
        check({tag, ".hmaster"}, 32'(Hmaster), 32'(m));
        check({tag, ".hmaster_d"}, 32'(Hmaster_d), 32'(md));
        check({tag, ".hmastlock"}, 32'(Hmastlock), 32'(l));
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] lck, input logic [1:0] tr,
                         input logic [2:0] bu, input logic rdy);
        Hbusreq_M = req;
        Hlock_M   = lck;
        Htrans    = tr;
        Hburst    = bu;
        Hready    = rdy;
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101;

    initial begin
        Hresetn = 1'b1;
        drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
        #1 Hresetn = 1'b0;
        #1 check_bus("reset", 4'b0001, 0, 0, 1'b0);
        #20 Hresetn = 1'b1;

        // Parking on the default master with no requests.
        for (int i = 0; i < 10; i++) begin
            tick();
            check_bus($sformatf("park%0d", i), 4'b0001, 0, 0, 1'b0);
        end

        // Two requesters, single transfers every beat.
        drive(4'b0110, 4'b0000, NSEQ, SINGLE, 1'b1);
        tick(); check_bus("rr_e1", 4'b0010, 0, 0, 1'b0);
        tick(); check_bus("rr_e2", FIXED ? 4'b0010 : 4'b0100, 1, 0, 1'b0);
        tick(); check_bus("rr_e3", 4'b0010, FIXED ? 1 : 2, 1, 1'b0);
        tick(); check_bus("rr_e4", FIXED ? 4'b0010 : 4'b0100, 1, FIXED ? 1 : 2, 1'b0);

        // M1 takes the bus, then runs INCR4 with two wait states; M1 drops its request mid burst.
        drive(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
        tick(); check_bus("b_own1", 4'b0010, FIXED ? 1 : 2, 1, 1'b0);
        tick(); check_bus("b_own2", 4'b0010, 1, FIXED ? 1 : 2, 1'b0);
        drive(4'b1010, 4'b0000, NSEQ, INCR4, 1'b1);
        tick(); check_bus("b_beat1", 4'b0010, 1, 1, 1'b0);
        drive(4'b1000, 4'b0000, SEQ, INCR4, 1'b1);
        tick(); check_bus("b_beat2", 4'b0010, 1, 1, 1'b0);
        drive(4'b1000, 4'b0000, SEQ, INCR4, 1'b0);
        tick(); check_bus("b_wait1", 4'b0010, 1, 1, 1'b0);
        tick(); check_bus("b_wait2", 4'b0010, 1, 1, 1'b0);
        drive(4'b1000, 4'b0000, SEQ, INCR4, 1'b1);
        tick(); check_bus("b_beat3", 4'b0010, 1, 1, 1'b0);
        tick(); check_bus("b_beat4", 4'b1000, 1, 1, 1'b0);
        drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
        tick(); check_bus("b_park1", 4'b0001, 3, 1, 1'b0);
        tick(); check_bus("b_park2", 4'b0001, 0, 3, 1'b0);

        // M2 performs three locked transfers then one unlocked transfer.
        drive(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
        tick(); check_bus("lk_own", 4'b0100, 0, 0, 1'b0);
        drive(4'b1101, 4'b0100, IDLE, SINGLE, 1'b1);
        tick(); check_bus("lk_l1", 4'b0100, 2, 0, 1'b1);
        drive(4'b1101, 4'b0100, NSEQ, SINGLE, 1'b1);
        tick(); check_bus("lk_l2", 4'b0100, 2, 2, 1'b1);
        tick(); check_bus("lk_l3", 4'b0100, 2, 2, 1'b1);
        drive(4'b1101, 4'b0000, NSEQ, SINGLE, 1'b1);
        tick(); check_bus("lk_unl", 4'b0100, 2, 2, 1'b0);
        tick(); check_bus("lk_move", FIXED ? 4'b0001 : 4'b1000, 2, 2, 1'b0);

        // Reset asserted during beat 3 of an INCR8 owned by M3.
        drive(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1);
        tick(); check_bus("rs_own", 4'b1000, FIXED ? 0 : 3, 2, 1'b0);
        drive(4'b1000, 4'b0000, NSEQ, INCR8, 1'b1);
        tick(); check_bus("rs_beat1", 4'b1000, 3, FIXED ? 0 : 3, 1'b0);
        drive(4'b1000, 4'b0000, SEQ, INCR8, 1'b1);
        tick(); check_bus("rs_beat2", 4'b1000, 3, 3, 1'b0);
        #3 Hresetn = 1'b0;
        #1 check_bus("rs_async", 4'b0001, 0, 0, 1'b0);
        #2 Hresetn = 1'b1;
        drive(4'b1001, 4'b0000, SEQ, INCR8, 1'b1);
        tick(); check_bus("rs_restart", FIXED ? 4'b0001 : 4'b1000, 0, 0, 1'b0);

        // M1 and M3 requesting: fixed priority keeps M1, round-robin alternates.
        drive(4'b1010, 4'b0000, NSEQ, SINGLE, 1'b1);
        tick(); check_bus("pr_e1", 4'b0010, FIXED ? 0 : 3, 0, 1'b0);
        tick(); check_bus("pr_e2", FIXED ? 4'b0010 : 4'b1000, 1, FIXED ? 0 : 3, 1'b0);
        tick(); check_bus("pr_e3", 4'b0010, FIXED ? 1 : 3, 1, 1'b0);
        drive(4'b1000, 4'b0000, NSEQ, SINGLE, 1'b1);
        tick(); check_bus("pr_e4", 4'b1000, 1, FIXED ? 1 : 3, 1'b0);
        tick(); check_bus("pr_e5", 4'b1000, 3, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
